// File: rtl/mux_seq_pkg.sv
// Shared types and constants for the 4:1 mux select sequencer.
package mux_seq_pkg;
    localparam int         NCH     = 4;
    localparam int         SEL_W   = 2;
    localparam logic [1:0] LAST_CH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;
endpackage

// File: rtl/mux_seq_dwell_cnt.sv
// Loadable down-counter timing the per-channel settle window; clear wins over load.
module mux_seq_dwell_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     value <= '0;
        else if (clear) value <= '0;
        else if (load)  value <= load_val;
        else if (dec)   value <= value - 1'b1;
    end

    assign zero = (value == '0);
endmodule

// File: rtl/mux_sel_sequencer.sv
// Sweeps mux select 0..3, samples mux_out after DWELL settle cycles, assembles 4-bit frames.
// Optional frame parity output enabled by defining MUX_SEQ_PARITY_EN.
module mux_sel_sequencer
    import mux_seq_pkg::*;
#(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             mux_out,
    output logic [SEL_W-1:0] s,
    output logic             busy,
    output logic             sample_vld,
    output logic [SEL_W-1:0] sample_ch,
    output logic             sample_bit,
    output logic [NCH-1:0]   frame,
    output logic             frame_vld
`ifdef MUX_SEQ_PARITY_EN
    ,
    output logic             frame_par
`endif
);
    state_t           state, state_nxt;
    logic             mode_q;
    logic [NCH-2:0]   shadow;
    logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             capture;

    mux_seq_dwell_cnt #(.CNT_W(CNT_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (cnt_clr),
        .load     (cnt_load),
        .load_val (CNT_W'(DWELL - 1)),
        .dec      (cnt_dec),
        .value    (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture happens on the edge leaving the last SETTLE cycle, so the sample
    // outputs are registered and valid throughout the SAMPLE cycle.
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        capture   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state_nxt = SETTLE;
                    cnt_load  = 1'b1;
                end
                SETTLE: if (cnt_zero) begin
                    state_nxt = SAMPLE;
                    capture   = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
                SAMPLE: if (s != LAST_CH || mode_q) begin
                    state_nxt = SETTLE;
                    cnt_load  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s          <= '0;
            mode_q     <= 1'b0;
            shadow     <= '0;
            sample_vld <= 1'b0;
            sample_ch  <= '0;
            sample_bit <= 1'b0;
            frame      <= '0;
            frame_vld  <= 1'b0;
        end else begin
            sample_vld <= capture;
            frame_vld  <= capture && (s == LAST_CH);
            if (abort) begin
                s      <= '0;
                shadow <= '0;
            end else begin
                if (state == IDLE && start) mode_q <= mode;
                // s+1 wraps 3->0 for both continuous and the return to IDLE.
                if (state == SAMPLE) s <= s + 1'b1;
                if (capture) begin
                    sample_ch  <= s;
                    sample_bit <= mux_out;
                    for (int i = 0; i < NCH - 1; i++)
                        if (s == SEL_W'(i)) shadow[i] <= mux_out;
                    if (s == LAST_CH) frame <= {mux_out, shadow};
                end
            end
        end
    end

`ifdef MUX_SEQ_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              frame_par <= 1'b0;
        else if (!abort && capture && s == LAST_CH) frame_par <= ^{mux_out, shadow};
    end
`endif

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer driving a behavioural 4:1 mux from s.
module tb_mux_sel_sequencer;
    localparam int D = 2;
    localparam int P = D + 1;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
        logic       b;
        logic       fv;
        logic [3:0] fr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, start, mode, abort, mux_out;
    logic [1:0] s, sample_ch;
    logic       busy, sample_vld, sample_bit, frame_vld;
    logic [3:0] frame, a;
`ifdef MUX_SEQ_PARITY_EN
    logic       frame_par;
`endif

    int   vecs = 0, errs = 0;
    int   cyc = 0, base = 0;
    exp_t sb[$];
    exp_t e;

    assign mux_out = a[s];

    mux_sel_sequencer #(.DWELL(D), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .abort      (abort),
        .mux_out    (mux_out),
        .s          (s),
        .busy       (busy),
        .sample_vld (sample_vld),
        .sample_ch  (sample_ch),
        .sample_bit (sample_bit),
        .frame      (frame),
        .frame_vld  (frame_vld)
`ifdef MUX_SEQ_PARITY_EN
        ,
        .frame_par  (frame_par)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (rel cycle %0d)", nm, act, want, cyc - base);
        end
    endtask

    task automatic to_rel(input int r);
        while (cyc - base < r) @(negedge clk);
    endtask

    // Pulse start in rel cycle 0 (the negedge where base is recorded).
    task automatic start_sweep(input logic m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        base  = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Queue one sweep's expected samples; sw selects which sweep of a continuous run.
    task automatic push_sweep(input logic [3:0] av, input int sw, input int nch);
        exp_t x;
        for (int k = 0; k < nch; k++) begin
            x.cyc = (sw * 4 + k + 1) * P;
            x.ch  = 2'(k);
            x.b   = av[k];
            x.fv  = (k == 3);
            x.fr  = av;
            sb.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (sample_vld || frame_vld)) begin
            if (sb.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_sample: ch=%0d bit=%0b frame_vld=%0b, expected no pulse",
                         sample_ch, sample_bit, frame_vld);
            end else begin
                e = sb.pop_front();
                check("sample_cycle", cyc - base, e.cyc);
                check("sample_vld", {31'd0, sample_vld}, 1);
                check("sample_ch", {30'd0, sample_ch}, {30'd0, e.ch});
                check("sample_bit", {31'd0, sample_bit}, {31'd0, e.b});
                check("frame_vld", {31'd0, frame_vld}, {31'd0, e.fv});
                if (e.fv) begin
                    check("frame", {28'd0, frame}, {28'd0, e.fr});
`ifdef MUX_SEQ_PARITY_EN
                    check("frame_par", {31'd0, frame_par}, {31'd0, ^e.fr});
`endif
                end
            end
        end
    end

    initial begin
        int seen;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; a = 4'b0000;
        #3;
        check("rst_s", {30'd0, s}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_frame", {28'd0, frame}, 0);
        check("rst_pulses", {30'd0, sample_vld, frame_vld}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single sweep a=1010.
        a = 4'b1010;
        start_sweep(1'b0);
        push_sweep(a, 0, 4);
        to_rel(2);  check("s_ch0", {30'd0, s}, 0);
        to_rel(5);  check("s_ch1", {30'd0, s}, 1);
        to_rel(8);  check("s_ch2", {30'd0, s}, 2);
        to_rel(11); check("s_ch3", {30'd0, s}, 3);
        to_rel(12); check("busy_at12", {31'd0, busy}, 1);
        to_rel(13); check("busy_at13", {31'd0, busy}, 0);
        check("frame_hold", {28'd0, frame}, 4'b1010);

        // Continuous: 0110 then 1001, stopped by abort in the second frame's SAMPLE cycle.
        a = 4'b0110;
        start_sweep(1'b1);
        push_sweep(4'b0110, 0, 4);
        push_sweep(4'b1001, 1, 4);
        to_rel(12); a = 4'b1001;
        to_rel(13);
        check("wrap_s0", {30'd0, s}, 0);
        check("wrap_busy", {31'd0, busy}, 1);
        to_rel(24); abort = 1'b1;
        to_rel(25); abort = 1'b0;
        check("cont_abort_idle", {31'd0, busy}, 0);

        // Establish frame=0011, then abort a sweep of 1100 at rel cycle 7.
        a = 4'b0011;
        start_sweep(1'b0);
        push_sweep(a, 0, 4);
        to_rel(14);
        a = 4'b1100;
        start_sweep(1'b0);
        push_sweep(a, 0, 2);
        to_rel(7); abort = 1'b1;
        to_rel(8); abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_s", {30'd0, s}, 0);
        check("abort_frame", {28'd0, frame}, 4'b0011);
        seen = 0;
        repeat (12) begin @(negedge clk); if (sample_vld || frame_vld) seen++; end
        check("abort_no_pulse", seen, 0);
        check("abort_frame_hold", {28'd0, frame}, 4'b0011);
        start_sweep(1'b0);
        push_sweep(a, 0, 4);
        to_rel(13);
        check("post_abort_frame", {28'd0, frame}, 4'b1100);

        // Start pulse (with mode=1) while busy is ignored.
        a = 4'b0101;
        start_sweep(1'b0);
        push_sweep(a, 0, 4);
        to_rel(4); start = 1'b1; mode = 1'b1;
        to_rel(5); start = 1'b0; mode = 1'b0;
        to_rel(13);
        check("ignored_start_busy", {31'd0, busy}, 0);

        // Parity patterns (frame_par checked in parity builds).
        a = 4'b0111;
        start_sweep(1'b0);
        push_sweep(a, 0, 4);
        to_rel(13);

        // Abort and start together in IDLE: abort wins.
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("tie_busy", {31'd0, busy}, 0);
        @(negedge clk);
        check("tie_busy_later", {31'd0, busy}, 0);

        // Asynchronous reset mid-sweep at rel cycle 5.
        a = 4'b0110;
        start_sweep(1'b0);
        push_sweep(a, 0, 1);
        to_rel(5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_s", {30'd0, s}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_frame", {28'd0, frame}, 0);
        check("arst_pulses", {30'd0, sample_vld, frame_vld}, 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (15) begin @(negedge clk); if (busy || sample_vld) seen++; end
        check("arst_stays_idle", seen, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
